alarm_clock_core: RTL
=====================

Name: alarm_clock_core

Overview:
- Parametrised time-keeping and alarm core for the board-level digital clock.
- Keeps HH:MM:SS from an external 1 Hz strobe and holds one alarm time.
- Runs the button-driven adjust state machine for clock and alarm, and drives alarm ring, snooze and timeout.
- Emits packed BCD digits for the 4-digit multiplexed seven-segment display path, plus blink and status flags.

Parameters:
- HOUR_24, 1: 1 = 24-hour display (00-23); 0 = 12-hour display (12,01..11) with pm flag.
- SNOOZE_MIN, 5: minutes added to the current time on snooze; legal range 1..59.
- RING_SECS, 60: 1 Hz ticks the alarm rings before auto-dismiss; legal range 1..255.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- tick_1hz  in  1  one-cycle strobe, once per second.
- btn_c, btn_r, btn_l, btn_u, btn_d  in  1 each  debounced one-cycle button pulses.
- digits  out  16  BCD {hr_tens, hr_ones, min_tens, min_ones}, 4 bits each.
- seconds  out  6  binary seconds 0..59.
- pm  out  1  PM indicator; always 0 when HOUR_24=1.
- blink  out  2  field under adjust: 00 none, 01 minutes, 10 hours.
- show_alarm  out  1  digits currently show the alarm time.
- alarm_en  out  1  alarm armed.
- alarm_out  out  1  ringing.
- state_o  out  3  current FSM state, for LEDs and debug.

Behaviour:
- Reset (reset==0 at a clk edge):
  - time 00:00:00; alarm 00:00.
  - alarm_en=0, alarm_out=0, snooze pending cleared, ring counter=0.
  - state=CLOCK; all outputs as implied (digits=0, blink=00, show_alarm=0, pm=0).
- Internal format: hours are held binary 0..23; minutes and seconds binary 0..59. BCD conversion of the displayed value is combinational.
- 12-hour mapping (HOUR_24=0): display hour = 12 if h%12==0, else h%12; pm = (h>=12).
- Time advance applies in CLOCK, MENU, ADJ_ALM_MIN, ADJ_ALM_HR and RING:
  - On tick_1hz, seconds increments; 59 wraps to 0 and carries to minutes.
  - Minutes 59 wraps to 0 and carries to hours; hours 23 wraps to 0.
- In ADJ_CLK_MIN and ADJ_CLK_HR, ticks are ignored and seconds is forced to 0 on state entry.
- Buttons:
  - At most one button acts per cycle; priority C > R > L > U > D.
  - A tick in the same cycle is still applied wherever time advances.
- FSM states and transitions (unlisted button = stay in state):
  - CLOCK: C -> MENU; D toggles alarm_en (clearing alarm_en also clears snooze).
  - MENU: C -> CLOCK; R -> ADJ_CLK_MIN; L -> ADJ_ALM_MIN.
  - ADJ_CLK_MIN: C -> CLOCK; R -> ADJ_CLK_HR; L -> ADJ_ALM_MIN; U/D = minutes +1/-1.
  - ADJ_CLK_HR: C -> CLOCK; R -> ADJ_CLK_MIN; L -> ADJ_ALM_HR; U/D = hours +1/-1.
  - ADJ_ALM_MIN: C -> CLOCK; R -> ADJ_ALM_HR; L -> ADJ_CLK_MIN; U/D = alarm minutes ±1.
  - ADJ_ALM_HR: C -> CLOCK; R -> ADJ_ALM_MIN; L -> ADJ_CLK_HR; U/D = alarm hours ±1.
  - RING: see alarm rules below.
- Adjust arithmetic:
  - Minutes 59+1 = 0 and 0-1 = 59; hours 23+1 = 0 and 0-1 = 23.
  - No carry or borrow between fields during adjust.
  - Any alarm-field edit clears snooze pending.
- Display outputs:
  - show_alarm=1 in ADJ_ALM_*; digits then show the alarm time.
  - Otherwise digits show the current time.
  - blink follows the adjusted field; 00 outside adjust states.
- Alarm trigger:
  - Condition, evaluated on the tick cycle after the increment: state==CLOCK, alarm_en=1, new seconds==0, and new HH:MM equals either the alarm time or the pending snooze target.
  - On trigger: next state RING, alarm_out=1 from the next cycle, ring counter=0.
  - A match while in a non-CLOCK state is missed; there is no catch-up.
- RING:
  - C: dismiss -> CLOCK; snooze cleared.
  - U: snooze target = current HH:MM + SNOOZE_MIN, with minute wrap carrying into hour and 23 -> 0; snooze pending=1; -> CLOCK.
  - Each tick increments the ring counter; reaching RING_SECS -> CLOCK with snooze cleared.
  - alarm_out=0 in every state other than RING.
- Reset in mid-adjust or mid-ring returns everything to reset values on that edge.

Test Plan:
- Reset, then 3600 ticks -> digits=0x0100, seconds=0. Then set time 23:59:59 and tick -> digits=0x0000, pm=0.
- Sequence C, R, U×61 -> minute field reads 01 (wrap, hours unchanged) and blink=01. Then R, D -> hours 23, blink=10. Then C -> state CLOCK, seconds=0.
- HOUR_24=0, time 00:30 -> digits=0x1230, pm=0. Time 13:05 -> digits=0x0105, pm=1.
- Alarm 07:00, alarm_en=1, time 06:59:59, tick -> alarm_out=1 next cycle. 60 more ticks with no button -> alarm_out=0, state CLOCK.
- Ringing at 07:00, btn_u -> alarm_out=0. At 07:05:00 tick -> ringing again. btn_c -> no ring at 07:10.
- btn_c and btn_d in the same cycle in CLOCK -> state MENU and alarm_en unchanged. A tick in that cycle still advances seconds.

Source files
------------

// File: rtl/alarm_clock_core.sv
`default_nettype none
// ============================================================================
// Module   : alarm_clock_core
// Purpose  : HH:MM:SS time keeping from a 1 Hz strobe, one alarm with snooze
//            and ring timeout, button-driven adjust FSM, and packed BCD
//            digits for a 4-digit seven-segment display.
// Revision : 1.0 - initial release
// ============================================================================
module alarm_clock_core #(
  parameter int HOUR_24    = 1,
  parameter int SNOOZE_MIN = 5,
  parameter int RING_SECS  = 60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick_1hz,
  input  logic        btn_c,
  input  logic        btn_r,
  input  logic        btn_l,
  input  logic        btn_u,
  input  logic        btn_d,
  output logic [15:0] digits,
  output logic [5:0]  seconds,
  output logic        pm,
  output logic [1:0]  blink,
  output logic        show_alarm,
  output logic        alarm_en,
  output logic        alarm_out,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    S_CLOCK       = 3'd0,
    S_MENU        = 3'd1,
    S_ADJ_CLK_MIN = 3'd2,
    S_ADJ_CLK_HR  = 3'd3,
    S_ADJ_ALM_MIN = 3'd4,
    S_ADJ_ALM_HR  = 3'd5,
    S_RING        = 3'd6
  } state_t;

  state_t     state, next_state;
  logic [5:0] sec, mn, al_mn, sn_mn;
  logic [4:0] hr, al_hr, sn_hr;
  logic       snz_pend, arm;
  logic [7:0] ring_cnt;

  // Binary 0..59 to two BCD digits.
  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    logic [3:0] tens, ones;
    tens = 4'(v / 6'd10);
    ones = 4'(v % 6'd10);
    return {tens, ones};
  endfunction

  // Only the highest-priority pressed button acts: C > R > L > U > D.
  logic act_c, act_r, act_l, act_u, act_d;
  assign act_c = btn_c;
  assign act_r = !btn_c && btn_r;
  assign act_l = !btn_c && !btn_r && btn_l;
  assign act_u = !btn_c && !btn_r && !btn_l && btn_u;
  assign act_d = !btn_c && !btn_r && !btn_l && !btn_u && btn_d;

  // Time runs everywhere except while the clock itself is being set.
  logic in_adj_clk, adv;
  assign in_adj_clk = (state == S_ADJ_CLK_MIN) || (state == S_ADJ_CLK_HR);
  assign adv        = !in_adj_clk;

  // Time after this cycle's tick, with cascaded seconds/minutes/hours carry.
  logic [5:0] t_sec, t_mn;
  logic [4:0] t_hr;
  always_comb begin
    t_sec = sec;
    t_mn  = mn;
    t_hr  = hr;
    if (adv && tick_1hz) begin
      if (sec == 6'd59) begin
        t_sec = 6'd0;
        if (mn == 6'd59) begin
          t_mn = 6'd0;
          t_hr = (hr == 5'd23) ? 5'd0 : hr + 5'd1;
        end else begin
          t_mn = mn + 6'd1;
        end
      end else begin
        t_sec = sec + 6'd1;
      end
    end
  end

  // Alarm fires on the tick that lands on HH:MM:00 of the alarm or snooze
  // target, only from CLOCK and only when no C/D press is acting this cycle.
  logic al_match, sn_match, trig;
  assign al_match = (t_hr == al_hr) && (t_mn == al_mn);
  assign sn_match = snz_pend && (t_hr == sn_hr) && (t_mn == sn_mn);
  assign trig     = (state == S_CLOCK) && tick_1hz && !act_c && !act_d && arm &&
                    (t_sec == 6'd0) && (al_match || sn_match);

  // Snooze target is the current HH:MM plus SNOOZE_MIN with hour carry.
  logic [6:0] snz_sum;
  logic [5:0] snz_mn_n;
  logic [4:0] snz_hr_n;
  always_comb begin
    snz_sum  = {1'b0, mn} + 7'(SNOOZE_MIN);
    snz_mn_n = snz_sum[5:0];
    snz_hr_n = hr;
    if (snz_sum >= 7'd60) begin
      snz_mn_n = 6'(snz_sum - 7'd60);
      snz_hr_n = (hr == 5'd23) ? 5'd0 : hr + 5'd1;
    end
  end

  logic [7:0] ring_nxt;
  logic       ring_done;
  assign ring_nxt  = ring_cnt + 8'd1;
  assign ring_done = tick_1hz && (ring_nxt == 8'(RING_SECS));

  logic enter_adj_clk;
  assign enter_adj_clk = ((next_state == S_ADJ_CLK_MIN) || (next_state == S_ADJ_CLK_HR)) &&
                         !in_adj_clk;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= S_CLOCK;
    else        state <= next_state;
  end

  // Next-state decode plus the state-driven display flags.
  always_comb begin
    next_state = state;
    blink      = 2'b00;
    show_alarm = 1'b0;
    case (state)
      S_CLOCK: begin
        if (act_c)     next_state = S_MENU;
        else if (trig) next_state = S_RING;
      end
      S_MENU: begin
        if (act_c)      next_state = S_CLOCK;
        else if (act_r) next_state = S_ADJ_CLK_MIN;
        else if (act_l) next_state = S_ADJ_ALM_MIN;
      end
      S_ADJ_CLK_MIN: begin
        blink = 2'b01;
        if (act_c)      next_state = S_CLOCK;
        else if (act_r) next_state = S_ADJ_CLK_HR;
        else if (act_l) next_state = S_ADJ_ALM_MIN;
      end
      S_ADJ_CLK_HR: begin
        blink = 2'b10;
        if (act_c)      next_state = S_CLOCK;
        else if (act_r) next_state = S_ADJ_CLK_MIN;
        else if (act_l) next_state = S_ADJ_ALM_HR;
      end
      S_ADJ_ALM_MIN: begin
        blink      = 2'b01;
        show_alarm = 1'b1;
        if (act_c)      next_state = S_CLOCK;
        else if (act_r) next_state = S_ADJ_ALM_HR;
        else if (act_l) next_state = S_ADJ_CLK_MIN;
      end
      S_ADJ_ALM_HR: begin
        blink      = 2'b10;
        show_alarm = 1'b1;
        if (act_c)      next_state = S_CLOCK;
        else if (act_r) next_state = S_ADJ_ALM_MIN;
        else if (act_l) next_state = S_ADJ_CLK_HR;
      end
      S_RING: begin
        if (act_c || act_u) next_state = S_CLOCK;
        else if (ring_done) next_state = S_CLOCK;
      end
      default: next_state = S_CLOCK;
    endcase
  end

  // Time, alarm, snooze and ring-counter registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sec      <= 6'd0;
      mn       <= 6'd0;
      hr       <= 5'd0;
      al_mn    <= 6'd0;
      al_hr    <= 5'd0;
      sn_mn    <= 6'd0;
      sn_hr    <= 5'd0;
      snz_pend <= 1'b0;
      arm      <= 1'b0;
      ring_cnt <= 8'd0;
    end else begin
      sec <= t_sec;
      mn  <= t_mn;
      hr  <= t_hr;
      case (state)
        S_CLOCK: begin
          if (act_d) begin
            arm <= !arm;
            if (arm) snz_pend <= 1'b0;
          end
          if (trig) ring_cnt <= 8'd0;
        end
        S_ADJ_CLK_MIN: begin
          if (act_u)      mn <= (mn == 6'd59) ? 6'd0 : mn + 6'd1;
          else if (act_d) mn <= (mn == 6'd0) ? 6'd59 : mn - 6'd1;
        end
        S_ADJ_CLK_HR: begin
          if (act_u)      hr <= (hr == 5'd23) ? 5'd0 : hr + 5'd1;
          else if (act_d) hr <= (hr == 5'd0) ? 5'd23 : hr - 5'd1;
        end
        S_ADJ_ALM_MIN: begin
          if (act_u || act_d) snz_pend <= 1'b0;
          if (act_u)      al_mn <= (al_mn == 6'd59) ? 6'd0 : al_mn + 6'd1;
          else if (act_d) al_mn <= (al_mn == 6'd0) ? 6'd59 : al_mn - 6'd1;
        end
        S_ADJ_ALM_HR: begin
          if (act_u || act_d) snz_pend <= 1'b0;
          if (act_u)      al_hr <= (al_hr == 5'd23) ? 5'd0 : al_hr + 5'd1;
          else if (act_d) al_hr <= (al_hr == 5'd0) ? 5'd23 : al_hr - 5'd1;
        end
        S_RING: begin
          if (act_c) begin
            snz_pend <= 1'b0;
          end else if (act_u) begin
            sn_mn    <= snz_mn_n;
            sn_hr    <= snz_hr_n;
            snz_pend <= 1'b1;
          end else if (tick_1hz) begin
            ring_cnt <= ring_nxt;
            if (ring_done) snz_pend <= 1'b0;
          end
        end
        default: ;
      endcase
      // Setting the clock always starts from a whole minute.
      if (enter_adj_clk) sec <= 6'd0;
    end
  end

  // Display path: pick time or alarm, map hours, convert to BCD.
  logic [4:0] disp_hr_raw, disp_hr;
  logic [5:0] disp_mn;
  assign disp_hr_raw = show_alarm ? al_hr : hr;
  assign disp_mn     = show_alarm ? al_mn : mn;

  generate
    if (HOUR_24 != 0) begin : g_hour24
      assign disp_hr = disp_hr_raw;
      assign pm      = 1'b0;
    end else begin : g_hour12
      logic [4:0] h_mod;
      assign h_mod   = (disp_hr_raw >= 5'd12) ? disp_hr_raw - 5'd12 : disp_hr_raw;
      assign disp_hr = (h_mod == 5'd0) ? 5'd12 : h_mod;
      assign pm      = (disp_hr_raw >= 5'd12);
    end
  endgenerate

  assign digits    = {to_bcd({1'b0, disp_hr}), to_bcd(disp_mn)};
  assign seconds   = sec;
  assign alarm_en  = arm;
  assign alarm_out = (state == S_RING);
  assign state_o   = state;

endmodule
`default_nettype wire
